// File: rtl/dly_tap_train.sv
// Per-lane IDELAYE2 tap trainer: sweeps all 32 taps on one lane at a time,
// finds the widest contiguous passing window and loads its centre tap.
module dly_tap_train #(
    parameter int unsigned NLANE      = 16,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned NSAMP      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               idelayctl_rdy,
    input  logic               sample_valid,
    input  logic [NLANE-1:0]   sample_ok,
    output logic [NLANE-1:0]   ld,
    output logic [4:0]         cntvaluein,
    output logic               busy,
    output logic               done,
    output logic [NLANE-1:0]   fail,
    output logic [NLANE*5-1:0] tap_final
);

    localparam int unsigned LaneW = (NLANE > 1) ? $clog2(NLANE) : 1;
    localparam logic [LaneW-1:0] LaneLast   = LaneW'(NLANE - 1);
    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]       SampLast   = 4'(NSAMP - 1);

    typedef enum logic [3:0] {
        StIdle, StWaitRdy, StLoad, StSettle, StSample, StEval,
        StClose, StCload, StCsettle, StNextLane, StDone
    } state_e;

    state_e             state_q, state_d;
    logic [LaneW-1:0]   lane_q, lane_d;
    logic [4:0]         tap_q, tap_d;
    logic [4:0]         run_start_q, run_start_d;
    logic [5:0]         run_len_q, run_len_d;
    logic [4:0]         best_start_q, best_start_d;
    logic [5:0]         best_len_q, best_len_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         samp_cnt_q, samp_cnt_d;
    logic               pass_q, pass_d;
    logic [NLANE-1:0]   ld_q, ld_d;
    logic [4:0]         cntval_q, cntval_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NLANE-1:0]   fail_q, fail_d;
    logic [NLANE*5-1:0] tap_final_q, tap_final_d;

    // Final window: the run still open at tap 31 competes with the best so far.
    logic       run_wins;
    logic [4:0] eff_start;
    logic [5:0] eff_len;
    logic [5:0] len_m1;
    logic [4:0] centre;
    logic       rdy_lost;

    // Centre of the winning window; a strict compare keeps the earlier window on ties.
    always_comb begin
        run_wins  = run_len_q > best_len_q;
        eff_start = run_wins ? run_start_q : best_start_q;
        eff_len   = run_wins ? run_len_q : best_len_q;
        len_m1    = eff_len - 6'd1;
        centre    = (eff_len == 6'd0) ? 5'd0 : eff_start + len_m1[5:1];
        rdy_lost  = !idelayctl_rdy &&
                    !(state_q inside {StIdle, StWaitRdy, StNextLane, StDone});
    end

    // Next-state logic and registered-output next values.
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        tap_d        = tap_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        cnt_d        = cnt_q;
        samp_cnt_d   = samp_cnt_q;
        pass_d       = pass_q;
        cntval_d     = cntval_q;
        fail_d       = fail_q;
        tap_final_d  = tap_final_q;
        ld_d         = '0;

        if (rdy_lost) begin
            // Losing IDELAYCTRL ready restarts the current lane from tap 0.
            state_d = StWaitRdy;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d     = StWaitRdy;
                        lane_d      = '0;
                        fail_d      = '0;
                        tap_final_d = '0;
                    end
                end
                StWaitRdy: begin
                    tap_d        = 5'd0;
                    run_start_d  = 5'd0;
                    run_len_d    = 6'd0;
                    best_start_d = 5'd0;
                    best_len_d   = 6'd0;
                    samp_cnt_d   = 4'd0;
                    if (idelayctl_rdy) state_d = StLoad;
                end
                StLoad: begin
                    cnt_d      = 8'd0;
                    samp_cnt_d = 4'd0;
                    pass_d     = 1'b1;
                    state_d    = StSettle;
                end
                StSettle: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SettleLast) state_d = StSample;
                end
                StSample: begin
                    if (sample_valid) begin
                        pass_d     = pass_q & sample_ok[lane_q];
                        samp_cnt_d = samp_cnt_q + 4'd1;
                        if (samp_cnt_q == SampLast) state_d = StEval;
                    end
                end
                StEval: begin
                    if (pass_q) begin
                        if (run_len_q == 6'd0) run_start_d = tap_q;
                        run_len_d = run_len_q + 6'd1;
                    end else begin
                        if (run_wins) begin
                            best_start_d = run_start_q;
                            best_len_d   = run_len_q;
                        end
                        run_len_d = 6'd0;
                    end
                    if (tap_q == 5'd31) begin
                        state_d = StClose;
                    end else begin
                        tap_d   = tap_q + 5'd1;
                        state_d = StLoad;
                    end
                end
                StClose: begin
                    best_start_d                = eff_start;
                    best_len_d                  = eff_len;
                    fail_d[lane_q]              = (eff_len == 6'd0);
                    tap_final_d[lane_q*5 +: 5]  = centre;
                    cntval_d                    = centre;
                    state_d                     = StCload;
                end
                StCload: begin
                    cnt_d   = 8'd0;
                    state_d = StCsettle;
                end
                StCsettle: begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == SettleLast) state_d = StNextLane;
                end
                StNextLane: begin
                    if (lane_q == LaneLast) begin
                        state_d = StDone;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        state_d = StWaitRdy;
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        if (state_d == StLoad) cntval_d = tap_d;
        if (state_d == StLoad || state_d == StCload) ld_d[lane_d] = 1'b1;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            lane_q       <= '0;
            tap_q        <= 5'd0;
            run_start_q  <= 5'd0;
            run_len_q    <= 6'd0;
            best_start_q <= 5'd0;
            best_len_q   <= 6'd0;
            cnt_q        <= 8'd0;
            samp_cnt_q   <= 4'd0;
            pass_q       <= 1'b0;
            ld_q         <= '0;
            cntval_q     <= 5'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= '0;
            tap_final_q  <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            tap_q        <= tap_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            cnt_q        <= cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            pass_q       <= pass_d;
            ld_q         <= ld_d;
            cntval_q     <= cntval_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            tap_final_q  <= tap_final_d;
        end
    end

    assign ld         = ld_q;
    assign cntvaluein = cntval_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign tap_final  = tap_final_q;

endmodule

// File: tb/tb_dly_tap_train.sv
// Directed bench for dly_tap_train: two lanes, per-tap pass masks model the read comparator.
module tb_dly_tap_train;

    localparam int unsigned NL     = 2;
    localparam int unsigned SETTLE = 2;
    localparam int unsigned NS     = 4;
    // Busy cycles for a full run: per lane WAIT + 32 taps + CLOSE + CLOAD + settle + NEXT_LANE.
    localparam int unsigned BUSY_LEN = NL * (1 + 32 * (2 + SETTLE + NS) + 3 + SETTLE) + 1;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            idelayctl_rdy;
    logic            sample_valid;
    logic [NL-1:0]   sample_ok;
    logic [NL-1:0]   ld;
    logic [4:0]      cntvaluein;
    logic            busy;
    logic            done;
    logic [NL-1:0]   fail;
    logic [NL*5-1:0] tap_final;

    typedef struct {
        string         tag;
        logic [NL*5-1:0] tap;
        logic [NL-1:0] fl;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mask [NL];
    bit          bad_en;
    int          k;
    int          checks;
    int          errors;
    int          busy_cyc;
    int          done_cnt;
    logic [NL-1:0] ld_prev;

    dly_tap_train #(
        .NLANE      (NL),
        .SETTLE_CYC (SETTLE),
        .NSAMP      (NS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .idelayctl_rdy (idelayctl_rdy),
        .sample_valid  (sample_valid),
        .sample_ok     (sample_ok),
        .ld            (ld),
        .cntvaluein    (cntvaluein),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .tap_final     (tap_final)
    );

    always #5 clk = ~clk;

    // Comparator model: lane passes where its mask bit at the current tap is set;
    // optionally one bad sample (the second of four) at tap 12 on lane 0.
    always @(negedge clk) begin
        if (ld != '0) k = 0;
        else if (k < 1000) k++;
        for (int i = 0; i < NL; i++) sample_ok[i] = mask[i][cntvaluein];
        if (bad_en && cntvaluein == 5'd12 && k == 4) sample_ok[0] = 1'b0;
    end

    // Load-strobe protocol checks and activity counters.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            assert ($onehot0(ld) === 1'b1) else begin
                errors++;
                $error("FAIL ld_onehot observed=%b expected=onehot0", ld);
            end
            checks++;
            assert (((ld != '0) && (ld_prev != '0)) === 1'b0) else begin
                errors++;
                $error("FAIL ld_back2back observed=%b prev=%b expected=no repeat", ld, ld_prev);
            end
        end
        ld_prev = ld;
        if (busy) busy_cyc++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int t = lo; t <= hi; t++) m[t] = 1'b1;
        return m;
    endfunction

    task automatic kick(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                        input logic [NL*5-1:0] etap, input logic [NL-1:0] efail);
        exp_t e;
        e.tag = tag;
        e.tap = etap;
        e.fl  = efail;
        sb.push_back(e);
        mask[0] = m0;
        mask[1] = m1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, 64'(busy), 64'd1);
    endtask

    task automatic finish_run();
        exp_t e;
        int   n = 0;
        bit   got = 0;
        int   d0 = done_cnt;
        while (!got && n < 3000) begin
            @(negedge clk);
            n++;
            if (done) got = 1;
        end
        e = sb.pop_front();
        check({e.tag, "_done_seen"}, 64'(got), 64'd1);
        check({e.tag, "_tap_final"}, 64'(tap_final), 64'(e.tap));
        check({e.tag, "_fail"}, 64'(fail), 64'(e.fl));
        check({e.tag, "_busy_at_done"}, 64'(busy), 64'd1);
        @(negedge clk);
        check({e.tag, "_done_pulse"}, 64'(done), 64'd0);
        check({e.tag, "_busy_fall"}, 64'(busy), 64'd0);
        check({e.tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int  n;
        bit  found;
        int  d0;
        checks        = 0;
        errors        = 0;
        busy_cyc      = 0;
        done_cnt      = 0;
        k             = 0;
        ld_prev       = '0;
        bad_en        = 0;
        mask[0]       = '0;
        mask[1]       = '0;
        reset_n       = 1'b0;
        start         = 1'b0;
        idelayctl_rdy = 1'b1;
        sample_valid  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ld", 64'(ld), 64'd0);
        check("reset_cntvaluein", 64'(cntvaluein), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_fail", 64'(fail), 64'd0);
        check("reset_tap_final", 64'(tap_final), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mid-range window plus full pass; a start pulse mid-run must be ignored.
        busy_cyc = 0;
        kick("mid", rng(10, 20), 32'hffff_ffff, {5'd15, 5'd15}, 2'b00);
        repeat (50) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_run();
        check("mid_busy_len", 64'(busy_cyc), 64'(BUSY_LEN));

        // Two windows: wider later wins on lane 0, tie keeps earlier on lane 1.
        kick("two_win", rng(3, 6) | rng(20, 27), rng(2, 5) | rng(12, 15),
             {5'd3, 5'd23}, 2'b00);
        finish_run();

        // Window ending at tap 31, and a lane that never passes.
        kick("edge_none", rng(28, 31), 32'h0, {5'd0, 5'd29}, 2'b10);
        finish_run();

        // One bad sample at tap 12 splits 5..20 into 5..11 and 13..20.
        bad_en = 1;
        kick("bad_samp", rng(5, 20), 32'hffff_ffff, {5'd15, 5'd16}, 2'b00);
        finish_run();
        bad_en = 0;

        // IDELAYCTRL ready drop during lane 1 tap 17.
        kick("rdy_drop", rng(10, 20), rng(8, 9), {5'd8, 5'd15}, 2'b00);
        n = 0;
        found = 0;
        while (!found && n < 2000) begin
            @(negedge clk);
            n++;
            if (ld == 2'b10 && cntvaluein == 5'd17) found = 1;
        end
        check("rdy_drop_reach_tap17", 64'(found), 64'd1);
        idelayctl_rdy = 1'b0;
        repeat (5) @(negedge clk);
        idelayctl_rdy = 1'b1;
        n = 0;
        found = 0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (ld != '0) found = 1;
        end
        check("rdy_drop_reload_seen", 64'(found), 64'd1);
        check("rdy_drop_reload_lane", 64'(ld), 64'(2'b10));
        check("rdy_drop_reload_tap", 64'(cntvaluein), 64'd0);
        check("rdy_drop_lane0_kept", 64'(tap_final[4:0]), 64'd15);
        finish_run();

        // Asynchronous reset in the middle of lane 1.
        mask[0] = rng(10, 20);
        mask[1] = 32'hffff_ffff;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_lane0_done", 64'(tap_final[4:0]), 64'd15);
        d0 = done_cnt;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({ld, cntvaluein, busy, done, fail, tap_final}), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (50) @(negedge clk);
        check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_mid_idle", 64'(busy), 64'd0);

        // Training works again after the reset.
        kick("post_rst", 32'hffff_ffff, rng(0, 0), {5'd0, 5'd15}, 2'b00);
        finish_run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
